// File: rtl/clause_array_io_ctrl.sv
// clause_array_io_ctrl
//   Initiator side of the clause-array load/readback interface. Loads a
//   valid/ready stream of clause literal vectors into consecutive clause
//   slots (one-hot wr strobe, lits, computed length), and dumps every slot
//   back out (one-hot rd strobe, capture, valid/ready output stream).
//
// Ports:
//   clk, rst             clock, synchronous active-low reset
//   start_load_i         begin load of num_clauses_i clauses (min'd to NUM_CLAUSES)
//   start_dump_i         begin dump of all NUM_CLAUSES slots
//   num_clauses_i        load count, sampled with start_load_i
//   busy_o, done_o       busy while not idle; one-cycle pulse at end of load/dump
//   in_valid_i/in_ready_o/in_lits_i     input clause stream
//   wr_o, clause_o, clause_len_o        registered slot write to the array
//   rd_o                                one-hot slot read strobe
//   clause_i, clause_len_i              array readback (lits OR-combined, per-slot lengths)
//   out_valid_o/out_ready_i             dumped clause stream
//   out_lits_o, out_len_o, out_reason_o dumped clause contents
module clause_array_io_ctrl #(
    parameter int NUM_VARS    = 8,
    parameter int NUM_CLAUSES = 8,
    parameter int WIDTH_C_LEN = 4,
    parameter int WIDTH_C_IDX = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start_load_i,
    input  logic                               start_dump_i,
    input  logic [WIDTH_C_IDX-1:0]             num_clauses_i,
    output logic                               busy_o,
    output logic                               done_o,
    input  logic                               in_valid_i,
    output logic                               in_ready_o,
    input  logic [NUM_VARS*2-1:0]              in_lits_i,
    output logic [NUM_CLAUSES-1:0]             wr_o,
    output logic [NUM_CLAUSES-1:0]             rd_o,
    output logic [NUM_VARS*2-1:0]              clause_o,
    output logic [WIDTH_C_LEN-1:0]             clause_len_o,
    input  logic [NUM_VARS*2-1:0]              clause_i,
    input  logic [WIDTH_C_LEN*NUM_CLAUSES-1:0] clause_len_i,
    output logic                               out_valid_o,
    input  logic                               out_ready_i,
    output logic [NUM_VARS*2-1:0]              out_lits_o,
    output logic [WIDTH_C_LEN-1:0]             out_len_o,
    output logic                               out_reason_o
);

    localparam int LW = NUM_VARS * 2;
    localparam int unsigned LEN_MAX = (1 << WIDTH_C_LEN) - 1;
    localparam logic [WIDTH_C_IDX-1:0] NUM_CL   = WIDTH_C_IDX'(NUM_CLAUSES);
    localparam logic [WIDTH_C_IDX-1:0] LAST_IDX = WIDTH_C_IDX'(NUM_CLAUSES - 1);
    localparam logic [WIDTH_C_IDX-1:0] IDX_ONE  = WIDTH_C_IDX'(1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LOAD_END,
        DUMP_RD,
        DUMP_OUT
    } state_t;

    state_t                   state, state_nxt;
    logic [WIDTH_C_IDX-1:0]   idx, idx_nxt;
    logic [WIDTH_C_IDX-1:0]   cnt_tgt, cnt_tgt_nxt;
    logic [NUM_CLAUSES-1:0]   wr_nxt;
    logic [LW-1:0]            clause_nxt, out_lits_nxt;
    logic [WIDTH_C_LEN-1:0]   clause_len_nxt, out_len_nxt;
    logic [WIDTH_C_LEN-1:0]   in_len, rd_len;
    logic                     done_nxt, out_reason_nxt;
    int unsigned              nz_cnt;

    // Number of nonzero 2-bit literal fields, saturated to the length width.
    always_comb begin
        nz_cnt = 0;
        for (int unsigned v = 0; v < NUM_VARS; v++) begin
            if (in_lits_i[2*v +: 2] != 2'b00) nz_cnt = nz_cnt + 1;
        end
        in_len = (nz_cnt > LEN_MAX) ? WIDTH_C_LEN'(LEN_MAX) : WIDTH_C_LEN'(nz_cnt);
    end

    assign rd_len = clause_len_i[int'(idx)*WIDTH_C_LEN +: WIDTH_C_LEN];

    // State-decoded outputs go to zero the cycle after reset forces IDLE.
    assign busy_o      = (state != IDLE);
    assign in_ready_o  = (state == LOAD);
    assign out_valid_o = (state == DUMP_OUT);
    assign rd_o        = (state == DUMP_RD) ? (NUM_CLAUSES'(1) << idx) : '0;

    always_comb begin
        state_nxt      = state;
        idx_nxt        = idx;
        cnt_tgt_nxt    = cnt_tgt;
        wr_nxt         = '0;
        clause_nxt     = '0;
        clause_len_nxt = '0;
        done_nxt       = 1'b0;
        out_lits_nxt   = out_lits_o;
        out_len_nxt    = out_len_o;
        out_reason_nxt = out_reason_o;
        case (state)
            IDLE: begin
                // Load has priority; a simultaneous dump request is dropped.
                if (start_load_i) begin
                    cnt_tgt_nxt = (num_clauses_i > NUM_CL) ? NUM_CL : num_clauses_i;
                    idx_nxt     = '0;
                    if (num_clauses_i == '0) done_nxt = 1'b1;
                    else                     state_nxt = LOAD;
                end else if (start_dump_i) begin
                    idx_nxt   = '0;
                    state_nxt = DUMP_RD;
                end
            end
            LOAD: begin
                if (in_valid_i) begin
                    wr_nxt         = NUM_CLAUSES'(1) << idx;
                    clause_nxt     = in_lits_i;
                    clause_len_nxt = in_len;
                    if (idx == cnt_tgt - IDX_ONE) state_nxt = LOAD_END;
                    else                          idx_nxt   = idx + IDX_ONE;
                end
            end
            LOAD_END: begin
                done_nxt  = 1'b1;
                state_nxt = IDLE;
            end
            DUMP_RD: begin
                out_lits_nxt   = clause_i;
                out_len_nxt    = rd_len;
                out_reason_nxt = (rd_len == '0) && (clause_i != '0);
                state_nxt      = DUMP_OUT;
            end
            DUMP_OUT: begin
                if (out_ready_i) begin
                    if (idx == LAST_IDX) begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        idx_nxt   = idx + IDX_ONE;
                        state_nxt = DUMP_RD;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            idx          <= '0;
            cnt_tgt      <= '0;
            wr_o         <= '0;
            clause_o     <= '0;
            clause_len_o <= '0;
            done_o       <= 1'b0;
            out_lits_o   <= '0;
            out_len_o    <= '0;
            out_reason_o <= 1'b0;
        end else begin
            state        <= state_nxt;
            idx          <= idx_nxt;
            cnt_tgt      <= cnt_tgt_nxt;
            wr_o         <= wr_nxt;
            clause_o     <= clause_nxt;
            clause_len_o <= clause_len_nxt;
            done_o       <= done_nxt;
            out_lits_o   <= out_lits_nxt;
            out_len_o    <= out_len_nxt;
            out_reason_o <= out_reason_nxt;
        end
    end

endmodule

// File: tb/tb_clause_array_io_ctrl.sv
module tb_clause_array_io_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_load_i, start_dump_i;
    logic [3:0]  num_clauses_i;
    logic        busy_o, done_o;
    logic        in_valid_i, in_ready_o;
    logic [15:0] in_lits_i;
    logic [7:0]  wr_o, rd_o;
    logic [15:0] clause_o;
    logic [3:0]  clause_len_o;
    logic [15:0] clause_i;
    logic [31:0] clause_len_i;
    logic        out_valid_o, out_ready_i;
    logic [15:0] out_lits_o;
    logic [3:0]  out_len_o;
    logic        out_reason_o;

    int tests = 0;
    int fails = 0;

    // Clause array model: contents set by the stimulus, read back through rd_o.
    logic [15:0] mem_lits [8];
    logic [3:0]  mem_len  [8];

    always_comb begin
        clause_i     = '0;
        clause_len_i = '0;
        for (int k = 0; k < 8; k++) begin
            if (rd_o[k]) clause_i = clause_i | mem_lits[k];
            clause_len_i[k*4 +: 4] = mem_len[k];
        end
    end

    always #5 clk = ~clk;

    clause_array_io_ctrl #(
        .NUM_VARS(8), .NUM_CLAUSES(8), .WIDTH_C_LEN(4), .WIDTH_C_IDX(4)
    ) dut (
        .clk(clk), .rst(rst),
        .start_load_i(start_load_i), .start_dump_i(start_dump_i),
        .num_clauses_i(num_clauses_i),
        .busy_o(busy_o), .done_o(done_o),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_lits_i(in_lits_i),
        .wr_o(wr_o), .rd_o(rd_o), .clause_o(clause_o), .clause_len_o(clause_len_o),
        .clause_i(clause_i), .clause_len_i(clause_len_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_lits_o(out_lits_o), .out_len_o(out_len_o), .out_reason_o(out_reason_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0]  onehot;
        logic [15:0] exp_lits [8];
        logic [3:0]  exp_len  [8];
        logic [7:0]  exp_rsn;
        bit          saw_done;

        rst = 1'b0; start_load_i = 0; start_dump_i = 0; num_clauses_i = 0;
        in_valid_i = 0; in_lits_i = 0; out_ready_i = 0;
        for (int k = 0; k < 8; k++) begin
            mem_lits[k] = '0;
            mem_len[k]  = '0;
        end
        tick(); tick();

        // Reset state
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_wr", 32'(wr_o), 0);
        chk("rst_rd", 32'(rd_o), 0);
        chk("rst_in_ready", 32'(in_ready_o), 0);
        chk("rst_out_valid", 32'(out_valid_o), 0);
        chk("rst_clause_len", 32'(clause_len_o), 0);
        rst = 1'b1;
        tick();

        // Load of 3 clauses with in_valid held high
        start_load_i = 1; num_clauses_i = 4'd3;
        tick();
        start_load_i = 0; in_valid_i = 1; in_lits_i = 16'h0009;
        chk("l3_in_ready", 32'(in_ready_o), 1);
        chk("l3_busy", 32'(busy_o), 1);
        tick();
        chk("l3_wr0", 32'(wr_o), 32'h01);
        chk("l3_lits0", 32'(clause_o), 32'h0009);
        chk("l3_len0", 32'(clause_len_o), 2);
        in_lits_i = 16'h0155;
        tick();
        chk("l3_wr1", 32'(wr_o), 32'h02);
        chk("l3_lits1", 32'(clause_o), 32'h0155);
        // 0x0155: fields 0..4 are 01, fields 5..7 are 00 -> five nonzero
        chk("l3_len1", 32'(clause_len_o), 5);
        in_lits_i = 16'h8000;
        tick();
        chk("l3_wr2", 32'(wr_o), 32'h04);
        chk("l3_len2", 32'(clause_len_o), 1);
        chk("l3_ready_drop", 32'(in_ready_o), 0);
        chk("l3_no_early_done", 32'(done_o), 0);
        tick();
        chk("l3_done", 32'(done_o), 1);
        chk("l3_wr_idle", 32'(wr_o), 0);
        chk("l3_clause_idle", 32'(clause_o), 0);
        chk("l3_busy_idle", 32'(busy_o), 0);
        in_valid_i = 0;
        tick();
        chk("l3_done_pulse", 32'(done_o), 0);

        // Load with count above NUM_CLAUSES: clamped to 8
        start_load_i = 1; num_clauses_i = 4'd12;
        tick();
        start_load_i = 0; in_valid_i = 1;
        for (int i = 0; i < 8; i++) begin
            in_lits_i = 16'(i + 1);
            tick();
            onehot = 8'h01 << i;
            chk("l12_wr", 32'(wr_o), 32'(onehot));
            chk("l12_lits", 32'(clause_o), 32'(i + 1));
        end
        chk("l12_ready_drop", 32'(in_ready_o), 0);
        tick();
        chk("l12_no_9th", 32'(wr_o), 0);
        chk("l12_done", 32'(done_o), 1);
        in_valid_i = 0;
        tick();

        // Zero-count load
        start_load_i = 1; num_clauses_i = 4'd0;
        tick();
        start_load_i = 0;
        chk("l0_busy", 32'(busy_o), 0);
        chk("l0_done", 32'(done_o), 1);
        chk("l0_wr", 32'(wr_o), 0);
        tick();
        chk("l0_done_pulse", 32'(done_o), 0);
        chk("l0_busy2", 32'(busy_o), 0);

        // Simultaneous starts: load wins
        start_load_i = 1; start_dump_i = 1; num_clauses_i = 4'd1;
        tick();
        start_load_i = 0; start_dump_i = 0;
        chk("both_in_ready", 32'(in_ready_o), 1);
        chk("both_rd", 32'(rd_o), 0);
        in_valid_i = 1; in_lits_i = 16'h0003;
        tick();
        in_valid_i = 0;
        chk("both_wr", 32'(wr_o), 32'h01);
        tick();
        chk("both_done", 32'(done_o), 1);
        tick();

        // Dump: slot 2 locked as reason, slot 5 ordinary, rest empty
        mem_lits[2] = 16'h0006; mem_len[2] = 4'd0;
        mem_lits[5] = 16'h0030; mem_len[5] = 4'd3;
        for (int k = 0; k < 8; k++) begin
            exp_lits[k] = '0;
            exp_len[k]  = '0;
        end
        exp_lits[2] = 16'h0006;
        exp_lits[5] = 16'h0030; exp_len[5] = 4'd3;
        exp_rsn = 8'b0000_0100;
        out_ready_i = 1;
        start_dump_i = 1;
        tick();
        start_dump_i = 0;
        for (int k = 0; k < 8; k++) begin
            onehot = 8'h01 << k;
            chk("d_rd", 32'(rd_o), 32'(onehot));
            chk("d_wr_quiet", 32'(wr_o), 0);
            tick();
            chk("d_valid", 32'(out_valid_o), 1);
            chk("d_rd_off", 32'(rd_o), 0);
            chk("d_lits", 32'(out_lits_o), 32'(exp_lits[k]));
            chk("d_len", 32'(out_len_o), 32'(exp_len[k]));
            chk("d_reason", 32'(out_reason_o), 32'(exp_rsn[k]));
            tick();
        end
        chk("d_done", 32'(done_o), 1);
        chk("d_valid_drop", 32'(out_valid_o), 0);
        chk("d_busy_drop", 32'(busy_o), 0);
        tick();

        // Dump with backpressure on slot 0
        mem_lits[0] = 16'h00A1; mem_len[0] = 4'd3;
        out_ready_i = 0;
        start_dump_i = 1;
        tick();
        start_dump_i = 0;
        chk("bp_rd0", 32'(rd_o), 32'h01);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(out_valid_o), 1);
            chk("bp_lits", 32'(out_lits_o), 32'h00A1);
            chk("bp_len", 32'(out_len_o), 3);
            chk("bp_rd_off", 32'(rd_o), 0);
            tick();
        end
        out_ready_i = 1;
        tick();
        chk("bp_rd1", 32'(rd_o), 32'h02);
        saw_done = 0;
        for (int i = 0; i < 40 && !saw_done; i++) begin
            tick();
            if (done_o) saw_done = 1;
        end
        chk("bp_done_seen", 32'(saw_done), 1);
        tick();

        // Reset in the middle of a load
        start_load_i = 1; num_clauses_i = 4'd5;
        tick();
        start_load_i = 0; in_valid_i = 1; in_lits_i = 16'h0001;
        tick();
        chk("ra_wr0", 32'(wr_o), 32'h01);
        tick();
        chk("ra_wr1", 32'(wr_o), 32'h02);
        rst = 1'b0;
        tick();
        chk("ra_wr", 32'(wr_o), 0);
        chk("ra_clause", 32'(clause_o), 0);
        chk("ra_busy", 32'(busy_o), 0);
        chk("ra_in_ready", 32'(in_ready_o), 0);
        chk("ra_done", 32'(done_o), 0);
        rst = 1'b1; in_valid_i = 0;
        tick();
        chk("ra_no_done", 32'(done_o), 0);
        chk("ra_no_wr", 32'(wr_o), 0);
        start_load_i = 1; num_clauses_i = 4'd1;
        tick();
        start_load_i = 0; in_valid_i = 1; in_lits_i = 16'h0002;
        tick();
        in_valid_i = 0;
        chk("ra_restart_wr", 32'(wr_o), 32'h01);
        tick();
        chk("ra_restart_done", 32'(done_o), 1);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
